dds_freq_ramp_scheduler: RTL and testbench

// - Sequences a linear frequency ramp on one DDS channel by issuing timed 64-bit commands.
// - Each command uses the 48-bit frequency-only encoding: dest sel 4'b0001.
// - Sits upstream of the channel's DDS controller command input (64-bit gpo word) via valid/ready.
// - Config is latched on start; the ramp runs autonomously until done, range error or abort.

---
 rtl/dds_seq_pkg.sv | 33 +++
 rtl/dds_freq_ramp_scheduler_if.sv | 19 +
 rtl/dds_dwell_timer.sv | 51 +++++
 rtl/dds_freq_ramp_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_dds_freq_ramp_scheduler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_seq_pkg
// Description : Shared types and helpers for the DDS command sequencers.
//               Holds the ramp FSM state type, the dest-sel nibble
//               encodings of the 64-bit DDS command word, and a helper that
//               packs a dest-sel nibble and a 60-bit payload into one word.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ramp_state_t;

    // Dest-sel nibble carried in cmd_data[63:60]
    localparam logic [3:0] DEST_FREQ32     = 4'b0000;
    localparam logic [3:0] DEST_FREQ48     = 4'b0001;
    localparam logic [3:0] DEST_AMP_FREQ   = 4'b0010;
    localparam logic [3:0] DEST_PHASE_FREQ = 4'b0011;
    localparam logic [3:0] DEST_TOFFSET    = 4'b0100;
    localparam logic [3:0] DEST_AMP_OFFSET = 4'b0101;

    function automatic logic [63:0] make_cmd(input logic [3:0]  dest,
                                             input logic [59:0] payload);
        return {dest, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_freq_ramp_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_freq_ramp_scheduler_if
// Description : Valid/ready command channel between the ramp scheduler and
//               the DDS controller command input.
//   cmd_valid  master -> slave   cmd_data holds a command
//   cmd_ready  slave  -> master  downstream accepts cmd_data
//   cmd_data   master -> slave   64-bit DDS command word
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_freq_ramp_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;

    modport master (output cmd_valid, output cmd_data, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dds_dwell_timer
// Description : Loadable down-counter that times the idle gap between two
//               ramp commands.
//   clk          clock
//   rst          synchronous active-high reset
//   i_load       load i_load_value (takes precedence over i_en)
//   i_en         decrement by one while non-zero
//   i_load_value value loaded on i_load
//   o_expired    high while the count equals 1 (last cycle of the gap)
// Revision    : 1.0 - initial release
// ============================================================================
module dds_dwell_timer #(
    parameter int DWELL_WIDTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_load,
    input  wire logic                   i_en,
    input  wire logic [DWELL_WIDTH-1:0] i_load_value,
    output logic                        o_expired
);

    logic [DWELL_WIDTH-1:0] r_count_q;
    logic [DWELL_WIDTH-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_value;
        end else if (i_en && (r_count_q != '0)) begin
            w_count_d = r_count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    // Expiring at 1 rather than 0 lets the owner leave its wait state on the
    // cycle the count reaches 1, so a gap of N cycles needs exactly N wait
    // cycles.
    assign o_expired = (r_count_q == {{(DWELL_WIDTH-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/dds_freq_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dds_freq_ramp_scheduler
// Description : Issues a linear frequency ramp to one DDS channel as a timed
//               series of 48-bit frequency-only commands over valid/ready.
//   CLK100MHZ     sole clock
//   reset         synchronous active-high reset
//   start         pulse; latches config when idle
//   abort         pulse; ends a running sequence
//   start_freq    first frequency word
//   step_freq     signed increment per step
//   num_steps     number of commands to issue
//   dwell         idle cycles between a handshake and the next valid
//   cmd           command channel (master side)
//   busy          high in any state except IDLE
//   done          one-cycle pulse on normal or range-error completion
//   aborted       one-cycle pulse when abort ends a sequence
//   err_range     sticky; next frequency would leave [0, 2^48-1]
//   steps_issued  commands handshaken in the current/last sequence
// Revision    : 1.0 - initial release
// ============================================================================
module dds_freq_ramp_scheduler
    import dds_seq_pkg::*;
#(
    parameter logic [3:0] CMD_DEST    = DEST_FREQ48,
    parameter int         COUNT_WIDTH = 16,
    parameter int         DWELL_WIDTH = 32
) (
    input  wire logic                   CLK100MHZ,
    input  wire logic                   reset,
    input  wire logic                   start,
    input  wire logic                   abort,
    input  wire logic [47:0]            start_freq,
    input  wire logic [47:0]            step_freq,
    input  wire logic [COUNT_WIDTH-1:0] num_steps,
    input  wire logic [DWELL_WIDTH-1:0] dwell,
    dds_freq_ramp_scheduler_if.master   cmd,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic                        err_range,
    output logic [COUNT_WIDTH-1:0]      steps_issued
);

    ramp_state_t            r_state_q,   w_state_d;
    logic [47:0]            r_cur_q,     w_cur_d;
    logic [47:0]            r_step_q,    w_step_d;
    logic [COUNT_WIDTH-1:0] r_num_q,     w_num_d;
    logic [DWELL_WIDTH-1:0] r_dwell_q,   w_dwell_d;
    logic [COUNT_WIDTH-1:0] r_steps_q,   w_steps_d;
    logic                   r_err_q,     w_err_d;
    logic                   r_aborted_q, w_aborted_d;

    logic                   w_hs;
    logic [COUNT_WIDTH-1:0] w_steps_inc;
    logic signed [49:0]     w_sum;
    logic                   w_out_of_range;
    logic                   w_timer_load;
    logic                   w_timer_en;
    logic                   w_timer_expired;

    assign w_hs        = (r_state_q == ISSUE) && cmd.cmd_ready;
    assign w_steps_inc = r_steps_q + 1'b1;

    // Frequency words are unsigned, the step is signed. Two extra bits hold
    // every possible sum: bit 49 flags a negative result, bit 48 flags a
    // result at or above 2^48. Either one means the ramp would wrap.
    assign w_sum          = $signed({2'b00, r_cur_q}) + $signed({{2{r_step_q[47]}}, r_step_q});
    assign w_out_of_range = w_sum[49] | w_sum[48];

    dds_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk          (CLK100MHZ),
        .rst          (reset),
        .i_load       (w_timer_load),
        .i_en         (w_timer_en),
        .i_load_value (r_dwell_q),
        .o_expired    (w_timer_expired)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cur_d      = r_cur_q;
        w_step_d     = r_step_q;
        w_num_d      = r_num_q;
        w_dwell_d    = r_dwell_q;
        w_steps_d    = r_steps_q;
        w_err_d      = r_err_q;
        w_aborted_d  = 1'b0;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_cur_d   = start_freq;
                    w_step_d  = step_freq;
                    w_num_d   = num_steps;
                    w_dwell_d = dwell;
                    w_steps_d = '0;
                    w_err_d   = 1'b0;
                    w_state_d = (num_steps == '0) ? DONE : ISSUE;
                end
            end

            ISSUE: begin
                // A word accepted in the same cycle as abort still counts.
                if (w_hs) begin
                    w_steps_d = w_steps_inc;
                end
                if (abort) begin
                    w_state_d   = IDLE;
                    w_aborted_d = 1'b1;
                end else if (w_hs) begin
                    w_timer_load = 1'b1;
                    if (w_steps_inc == r_num_q) begin
                        w_state_d = DONE;
                    end else if (w_out_of_range) begin
                        w_err_d   = 1'b1;
                        w_state_d = DONE;
                    end else begin
                        w_cur_d   = w_sum[47:0];
                        w_state_d = (r_dwell_q == '0) ? ISSUE : WAIT;
                    end
                end
            end

            WAIT: begin
                w_timer_en = 1'b1;
                if (abort) begin
                    w_state_d   = IDLE;
                    w_aborted_d = 1'b1;
                end else if (w_timer_expired) begin
                    w_state_d = ISSUE;
                end
            end

            DONE: begin
                w_state_d   = IDLE;
                w_aborted_d = abort;
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_cur_q     <= '0;
            r_step_q    <= '0;
            r_num_q     <= '0;
            r_dwell_q   <= '0;
            r_steps_q   <= '0;
            r_err_q     <= 1'b0;
            r_aborted_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_cur_q     <= w_cur_d;
            r_step_q    <= w_step_d;
            r_num_q     <= w_num_d;
            r_dwell_q   <= w_dwell_d;
            r_steps_q   <= w_steps_d;
            r_err_q     <= w_err_d;
            r_aborted_q <= w_aborted_d;
        end
    end

    assign busy          = (r_state_q != IDLE);
    assign done          = (r_state_q == DONE);
    assign aborted       = r_aborted_q;
    assign err_range     = r_err_q;
    assign steps_issued  = r_steps_q;
    assign cmd.cmd_valid = (r_state_q == ISSUE);
    // The word is forced to zero when not valid so the bus reads 0 at idle.
    assign cmd.cmd_data  = (r_state_q == ISSUE) ? make_cmd(CMD_DEST, {12'h000, r_cur_q}) : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_ramp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_freq_ramp_scheduler
// Description : Self-checking bench for dds_freq_ramp_scheduler. A table of
//               ramp configurations with hand-computed command counts, error
//               flags and done times, followed by directed sequences for
//               backpressure, abort and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_freq_ramp_scheduler;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [47:0] start_freq;
    logic [47:0] step_freq;
    logic [15:0] num_steps;
    logic [31:0] dwell;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err_range;
    logic [15:0] steps_issued;

    int checks = 0;
    int errors = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    dds_freq_ramp_scheduler_if cmd_if ();

    dds_freq_ramp_scheduler u_dut (
        .CLK100MHZ    (CLK100MHZ),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .start_freq   (start_freq),
        .step_freq    (step_freq),
        .num_steps    (num_steps),
        .dwell        (dwell),
        .cmd          (cmd_if),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .err_range    (err_range),
        .steps_issued (steps_issued)
    );

    typedef struct {
        logic [47:0] sf;
        logic [47:0] step;
        logic [15:0] n;
        logic [31:0] dw;
        int          exp_cmds;
        logic        exp_err;
        int          exp_done;   // cycle of the done pulse, start sampled at cycle 0
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 where the first
    // cmd_valid must already be visible.
    task automatic launch(input logic [47:0] sf, input logic [47:0] st,
                          input logic [15:0] n, input logic [31:0] dw);
        start_freq = sf;
        step_freq  = st;
        num_steps  = n;
        dwell      = dw;
        start      = 1'b1;
        @(negedge CLK100MHZ);
        start      = 1'b0;
    endtask

    function automatic logic [63:0] word(input logic [47:0] f);
        return {4'h1, 12'h000, f};
    endfunction

    logic [47:0] exp_f;
    int          idx;
    int          done_cyc;

    initial begin
        vecs[0] = '{48'h1000,           48'h10,             16'd3, 32'd2, 3, 1'b0, 8};
        vecs[1] = '{48'h500,            48'h1,              16'd4, 32'd0, 4, 1'b0, 5};
        vecs[2] = '{48'h1234,           48'h0,              16'd0, 32'd5, 0, 1'b0, 1};
        vecs[3] = '{48'h40,             48'h8,              16'd1, 32'd7, 1, 1'b0, 2};
        vecs[4] = '{48'hFFFF_FFFF_FFFE, 48'h1,              16'd2, 32'd0, 2, 1'b0, 3};
        vecs[5] = '{48'hFFFF_FFFF_FFF0, 48'h8,              16'd5, 32'd0, 2, 1'b1, 3};
        vecs[6] = '{48'h20,             48'hFFFF_FFFF_FFF0, 16'd4, 32'd1, 3, 1'b1, 6};

        reset            = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        start_freq       = '0;
        step_freq        = '0;
        num_steps        = '0;
        dwell            = '0;
        cmd_if.cmd_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge CLK100MHZ);
        reset = 1'b0;
        @(negedge CLK100MHZ);
        chk("rst_busy",      64'(busy),             64'h0);
        chk("rst_done",      64'(done),             64'h0);
        chk("rst_aborted",   64'(aborted),          64'h0);
        chk("rst_err",       64'(err_range),        64'h0);
        chk("rst_steps",     64'(steps_issued),     64'h0);
        chk("rst_valid",     64'(cmd_if.cmd_valid), 64'h0);
        chk("rst_data",      cmd_if.cmd_data,       64'h0);

        // ---------------- table-driven ramps, ready held high ----------------
        for (int v = 0; v < NV; v++) begin
            cmd_if.cmd_ready = 1'b1;
            launch(vecs[v].sf, vecs[v].step, vecs[v].n, vecs[v].dw);
            idx      = 0;
            done_cyc = -1;
            for (int c = 1; c <= 200; c++) begin
                if (cmd_if.cmd_valid) begin
                    exp_f = vecs[v].sf + 48'(idx) * vecs[v].step;
                    chk($sformatf("v%0d_freq%0d", v, idx), cmd_if.cmd_data, word(exp_f));
                    chk($sformatf("v%0d_vtime%0d", v, idx), 64'(c),
                        64'(1 + idx * (int'(vecs[v].dw) + 1)));
                    idx++;
                end
                if (done) begin
                    done_cyc = c;
                    break;
                end
                @(negedge CLK100MHZ);
            end
            chk($sformatf("v%0d_ncmds", v), 64'(idx),          64'(vecs[v].exp_cmds));
            chk($sformatf("v%0d_dtime", v), 64'(done_cyc),     64'(vecs[v].exp_done));
            chk($sformatf("v%0d_err", v),   64'(err_range),    64'(vecs[v].exp_err));
            chk($sformatf("v%0d_steps", v), 64'(steps_issued), 64'(vecs[v].exp_cmds));
            chk($sformatf("v%0d_busyd", v), 64'(busy),         64'h1);
            @(negedge CLK100MHZ);
            chk($sformatf("v%0d_done1", v), 64'(done),         64'h0);
            chk($sformatf("v%0d_idle", v),  64'(busy),         64'h0);
        end

        // err_range from the last vector stays set while idle
        repeat (3) @(negedge CLK100MHZ);
        chk("err_sticky", 64'(err_range), 64'h1);

        // ---------------- backpressure + start while busy ----------------
        cmd_if.cmd_ready = 1'b0;
        launch(48'h500, 48'h1, 16'd2, 32'd3);
        chk("bp_err_clr", 64'(err_range), 64'h0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_valid%0d", i), 64'(cmd_if.cmd_valid), 64'h1);
            chk($sformatf("bp_data%0d", i),  cmd_if.cmd_data,       word(48'h500));
            start      = (i == 1);
            start_freq = 48'h999;
            num_steps  = 16'd0;
            if (i == 5) cmd_if.cmd_ready = 1'b1;
            @(negedge CLK100MHZ);
        end
        // handshake taken at the end of cycle 6; gap of 3 cycles follows
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_gap%0d", i), 64'(cmd_if.cmd_valid), 64'h0);
            @(negedge CLK100MHZ);
        end
        chk("bp_steps1",  64'(steps_issued),     64'h1);
        chk("bp_valid2",  64'(cmd_if.cmd_valid), 64'h1);
        chk("bp_data2",   cmd_if.cmd_data,       word(48'h501));
        @(negedge CLK100MHZ);
        chk("bp_done",    64'(done),             64'h1);
        chk("bp_steps2",  64'(steps_issued),     64'h2);
        @(negedge CLK100MHZ);

        // ---------------- abort in WAIT, start ignored ----------------
        cmd_if.cmd_ready = 1'b1;
        launch(48'h700, 48'h100, 16'd3, 32'd4);
        chk("aw_valid0", 64'(cmd_if.cmd_valid), 64'h1);
        @(negedge CLK100MHZ);
        chk("aw_wait",   64'(cmd_if.cmd_valid), 64'h0);
        chk("aw_busy",   64'(busy),             64'h1);
        abort      = 1'b1;
        start      = 1'b1;
        start_freq = 48'hAAA;
        num_steps  = 16'd0;
        @(negedge CLK100MHZ);
        abort = 1'b0;
        start = 1'b0;
        chk("aw_aborted", 64'(aborted),          64'h1);
        chk("aw_busy0",   64'(busy),             64'h0);
        chk("aw_valid",   64'(cmd_if.cmd_valid), 64'h0);
        chk("aw_nodone",  64'(done),             64'h0);
        chk("aw_steps",   64'(steps_issued),     64'h1);
        @(negedge CLK100MHZ);
        chk("aw_abpulse", 64'(aborted),          64'h0);
        chk("aw_idle",    64'(busy),             64'h0);
        repeat (3) @(negedge CLK100MHZ);
        chk("aw_nomore",  64'(cmd_if.cmd_valid), 64'h0);

        // ---------------- abort together with a handshake ----------------
        launch(48'h800, 48'h1, 16'd5, 32'd0);
        chk("ah_valid", 64'(cmd_if.cmd_valid), 64'h1);
        abort = 1'b1;
        @(negedge CLK100MHZ);
        abort = 1'b0;
        chk("ah_steps",   64'(steps_issued),     64'h1);
        chk("ah_aborted", 64'(aborted),          64'h1);
        chk("ah_busy",    64'(busy),             64'h0);
        chk("ah_valid0",  64'(cmd_if.cmd_valid), 64'h0);
        @(negedge CLK100MHZ);
        chk("ah_valid1",  64'(cmd_if.cmd_valid), 64'h0);
        chk("ah_abpulse", 64'(aborted),          64'h0);

        // ---------------- reset mid-ISSUE ----------------
        launch(48'h900, 48'h1, 16'd3, 32'd0);
        @(negedge CLK100MHZ);
        chk("rm_valid", cmd_if.cmd_data, word(48'h901));
        reset            = 1'b1;
        cmd_if.cmd_ready = 1'b0;
        @(negedge CLK100MHZ);
        reset = 1'b0;
        chk("rm_valid0", 64'(cmd_if.cmd_valid), 64'h0);
        chk("rm_data0",  cmd_if.cmd_data,       64'h0);
        chk("rm_busy",   64'(busy),             64'h0);
        chk("rm_steps",  64'(steps_issued),     64'h0);
        chk("rm_done",   64'(done),             64'h0);
        chk("rm_abort",  64'(aborted),          64'h0);
        @(negedge CLK100MHZ);
        chk("rm_done1",  64'(done),             64'h0);
        chk("rm_abort1", 64'(aborted),          64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
